// File: rtl/alu_pkg.sv
// Shared opcode, state and width definitions for the iter_alu datapath.
package alu_pkg;

  localparam int OP_W = 4;

  typedef enum logic [OP_W-1:0] {
    OP_ADD  = 4'h0,
    OP_SHL  = 4'h1,
    OP_SHR  = 4'h2,
    OP_MOV  = 4'h3,
    OP_OR   = 4'h4,
    OP_XOR  = 4'h5,
    OP_AND  = 4'h6,
    OP_ADC  = 4'h7,
    OP_SHLN = 4'h8,
    OP_SHRN = 4'h9,
    OP_MUL  = 4'hA,
    OP_CMP  = 4'hD,
    OP_NOP  = 4'hF
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic logic is_shift_n(input alu_op_e op);
    return (op == OP_SHLN) || (op == OP_SHRN);
  endfunction

endpackage

// File: rtl/shift_add_mul.sv
// Unsigned shift-add multiplier: one partial product per cycle, WIDTH cycles per start.
// done flags the final step; product carries that step's result combinationally.
module shift_add_mul #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic [WIDTH:0]   w_sum;

  assign w_sum   = {1'b0, r_hi} + {1'b0, (r_lo[0] ? r_mcand : {WIDTH{1'b0}})};
  assign busy    = r_busy;
  assign done    = r_busy && (r_cnt == CNT_W'(1));
  // Next value of {hi,lo} after this step; equals a*b on the last step.
  assign product = {w_sum, r_lo[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mcand <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
    end else if (start) begin
      r_mcand <= a;
      r_hi    <= '0;
      r_lo    <= b;
      r_cnt   <= CNT_W'(WIDTH);
      r_busy  <= 1'b1;
    end else if (r_busy) begin
      r_hi  <= w_sum[WIDTH:1];
      r_lo  <= {w_sum[0], r_lo[WIDTH-1:1]};
      r_cnt <= r_cnt - CNT_W'(1);
      if (r_cnt == CNT_W'(1)) r_busy <= 1'b0;
    end
  end

endmodule

// File: rtl/iter_alu.sv
// Iterative ALU with valid/ready operand port, held result and C/Z/P/EQ flags.
// Define ITER_ALU_MUL_EN to build the shift-add multiplier; otherwise opcode A is a NOP.
//
//  state | meaning
//  IDLE  | in_ready high, waiting for operands
//  EXEC  | computing; 1 cycle, or one step per cycle for SHLN/SHRN/MUL
//  DONE  | out_valid high, result held until out_ready
module iter_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] rslt,
  output logic [WIDTH-1:0] rslt_hi,
  output logic             flag_c,
  output logic             flag_z,
  output logic             flag_p,
  output logic             flag_eq
);

  state_e           r_state;
  alu_op_e          r_op;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [CNT_W-1:0] r_cnt;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_rslt;
  logic [WIDTH-1:0] r_rslt_hi;
  logic             r_c;
  logic             r_z;
  logic             r_p;
  logic             r_eq;

  logic             w_accept;
  logic [CNT_W-1:0] w_cnt_raw;
  logic [CNT_W-1:0] w_cnt_sat;
  logic             w_cin;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_sh_nxt;
  logic             w_sh_out;
  logic             w_fin;
  logic [WIDTH-1:0] w_res;
  logic [WIDTH-1:0] w_res_hi;
  logic             w_c;
  logic             w_eq;
  logic             w_zp_we;

`ifdef ITER_ALU_MUL_EN
  logic               w_mul_start;
  logic               w_mul_busy;
  logic               w_mul_done;
  logic [2*WIDTH-1:0] w_mul_prod;

  assign w_accept    = in_valid && r_in_ready && !w_mul_busy;
  assign w_mul_start = w_accept && (op == OP_MUL);

  shift_add_mul #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (w_mul_start),
    .a       (in_a),
    .b       (in_b),
    .busy    (w_mul_busy),
    .done    (w_mul_done),
    .product (w_mul_prod)
  );
`else
  assign w_accept = in_valid && r_in_ready;
`endif

  assign w_cnt_raw = in_b[CNT_W-1:0];
  assign w_cnt_sat = (w_cnt_raw > CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : w_cnt_raw;
  assign w_cin     = (r_op == OP_ADC) ? r_c : 1'b0;
  assign w_sum     = {1'b0, r_a} + {1'b0, r_b} + {{WIDTH{1'b0}}, w_cin};

  always_comb begin
    w_fin    = 1'b1;
    w_res    = r_a;
    w_res_hi = '0;
    w_c      = r_c;
    w_eq     = r_eq;
    w_zp_we  = 1'b1;
    if (r_op == OP_SHLN) begin
      w_sh_nxt = {r_a[WIDTH-2:0], 1'b0};
      w_sh_out = r_a[WIDTH-1];
    end else begin
      w_sh_nxt = {1'b0, r_a[WIDTH-1:1]};
      w_sh_out = r_a[0];
    end
    case (r_op)
      OP_ADD, OP_ADC: {w_c, w_res} = w_sum;
      OP_SHL: begin
        w_res = {r_a[WIDTH-2:0], r_c};
        w_c   = r_a[WIDTH-1];
      end
      OP_SHR: begin
        w_res = {r_c, r_a[WIDTH-1:1]};
        w_c   = r_a[0];
      end
      OP_MOV: w_res = r_a;
      OP_OR:  w_res = r_a | r_b;
      OP_XOR: w_res = r_a ^ r_b;
      OP_AND: w_res = r_a & r_b;
      // r_a is the shift register; a zero count finishes at once with carry held.
      OP_SHLN, OP_SHRN: begin
        if (r_cnt != '0) begin
          w_res = w_sh_nxt;
          w_c   = w_sh_out;
          w_fin = (r_cnt == CNT_W'(1));
        end
      end
`ifdef ITER_ALU_MUL_EN
      OP_MUL: begin
        w_fin    = w_mul_done;
        w_res    = w_mul_prod[WIDTH-1:0];
        w_res_hi = w_mul_prod[2*WIDTH-1:WIDTH];
        w_c      = |w_mul_prod[2*WIDTH-1:WIDTH];
      end
`endif
      OP_CMP: begin
        w_res = r_a;
        w_eq  = (r_a == r_b);
      end
      default: w_zp_we = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_op        <= OP_ADD;
      r_a         <= '0;
      r_b         <= '0;
      r_cnt       <= '0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_rslt      <= '0;
      r_rslt_hi   <= '0;
      r_c         <= 1'b0;
      r_z         <= 1'b0;
      r_p         <= 1'b0;
      r_eq        <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_op       <= alu_op_e'(op);
            r_a        <= in_a;
            r_b        <= in_b;
            r_cnt      <= w_cnt_sat;
            r_in_ready <= 1'b0;
            r_state    <= EXEC;
          end else begin
            r_in_ready <= 1'b1;
          end
        end
        EXEC: begin
          if (w_fin) begin
            r_rslt      <= w_res;
            r_rslt_hi   <= w_res_hi;
            r_c         <= w_c;
            r_eq        <= w_eq;
            if (w_zp_we) begin
              r_z <= ~|w_res;
              r_p <= ^w_res;
            end
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end else if (is_shift_n(r_op)) begin
            r_a   <= w_sh_nxt;
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign rslt      = r_rslt;
  assign rslt_hi   = r_rslt_hi;
  assign flag_c    = r_c;
  assign flag_z    = r_z;
  assign flag_p    = r_p;
  assign flag_eq   = r_eq;

endmodule

// File: tb/tb_iter_alu.sv
// Scoreboard bench for iter_alu: directed ops push expectations, a monitor checks each result.
module tb_iter_alu;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b1;
  logic [3:0] op = 4'h0;
  logic [7:0] in_a = 8'h00;
  logic [7:0] in_b = 8'h00;
  logic       in_ready, out_valid;
  logic [7:0] rslt, rslt_hi;
  logic       flag_c, flag_z, flag_p, flag_eq;

  iter_alu #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .rslt      (rslt),
    .rslt_hi   (rslt_hi),
    .flag_c    (flag_c),
    .flag_z    (flag_z),
    .flag_p    (flag_p),
    .flag_eq   (flag_eq)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  r;
    logic [7:0]  rh;
    logic [3:0]  f;    // {c,z,p,eq}
    logic [31:0] lat;  // EXEC cycles
    logic [31:0] acc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   acc_rst;
  logic prev_ov = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_ov = 1'b0;
    end else begin
      if (out_valid && !prev_ov) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output actual=%0h required=none", rslt);
        end else begin
          mon_e = sb.pop_front();
          chk("rslt", rslt, mon_e.r);
          chk("rslt_hi", rslt_hi, mon_e.rh);
          chk("flags_czpe", {flag_c, flag_z, flag_p, flag_eq}, mon_e.f);
          chk("latency", cyc - mon_e.acc, mon_e.lat);
        end
      end
      prev_ov = out_valid;
    end
  end

  task automatic accept_op(input logic [3:0] o, input logic [7:0] a, input logic [7:0] b,
                           output int acc);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL in_ready_timeout actual=0 required=1");
    end
    op = o; in_a = a; in_b = b; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    acc = cyc;
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) begin
      checks++;
      errors++;
      $display("FAIL out_valid_timeout actual=0 required=1");
    end
  endtask

  task automatic run(input logic [3:0] o, input logic [7:0] a, input logic [7:0] b,
                     input logic [7:0] r, input logic [7:0] rh, input logic [3:0] f,
                     input int lat);
    int   acc;
    exp_t e;
    accept_op(o, a, b, acc);
    e.r = r; e.rh = rh; e.f = f; e.lat = lat; e.acc = acc;
    sb.push_back(e);
    wait_valid();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2 rst_n = 1'b0;
    #2;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_rslt", rslt, 0);
    chk("rst_flags", {flag_c, flag_z, flag_p, flag_eq}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1 chk("post_rst_in_ready", in_ready, 1);

    //   op    a      b      rslt   hi     czpe     lat
    run(4'h0, 8'hF0, 8'h20, 8'h10, 8'h00, 4'b1010, 1);
    run(4'h7, 8'h00, 8'h00, 8'h01, 8'h00, 4'b0010, 1);
    run(4'h8, 8'h81, 8'h03, 8'h08, 8'h00, 4'b0010, 3);
    run(4'h9, 8'h81, 8'h00, 8'h81, 8'h00, 4'b0000, 1);
    run(4'h9, 8'h81, 8'h0C, 8'h00, 8'h00, 4'b1100, 8);
    run(4'h1, 8'h81, 8'h00, 8'h03, 8'h00, 4'b1000, 1);
    run(4'hD, 8'h5A, 8'h5A, 8'h5A, 8'h00, 4'b1001, 1);
    run(4'hD, 8'h5A, 8'h5B, 8'h5A, 8'h00, 4'b1000, 1);
    run(4'h2, 8'h02, 8'h00, 8'h81, 8'h00, 4'b0000, 1);
    run(4'h5, 8'h0F, 8'hFF, 8'hF0, 8'h00, 4'b0000, 1);
    run(4'h6, 8'h0F, 8'hF0, 8'h00, 8'h00, 4'b0100, 1);
    run(4'h4, 8'h0F, 8'h10, 8'h1F, 8'h00, 4'b0010, 1);
    run(4'h3, 8'h07, 8'h00, 8'h07, 8'h00, 4'b0010, 1);
    run(4'hB, 8'h3C, 8'h11, 8'h3C, 8'h00, 4'b0010, 1);
`ifdef ITER_ALU_MUL_EN
    run(4'hA, 8'hFF, 8'hFF, 8'h01, 8'hFE, 4'b1010, 8);
    run(4'hF, 8'h66, 8'h00, 8'h66, 8'h00, 4'b1010, 1);
`else
    run(4'hA, 8'hFF, 8'hFF, 8'hFF, 8'h00, 4'b0010, 1);
    run(4'hF, 8'h66, 8'h00, 8'h66, 8'h00, 4'b0010, 1);
`endif

    // Backpressure: result held while a competing request is ignored.
    out_ready = 1'b0;
    accept_op(4'h0, 8'h80, 8'h80, acc_rst);
    sb.push_back('{r: 8'h00, rh: 8'h00, f: 4'b1100, lat: 1, acc: acc_rst});
    wait_valid();
    for (int i = 0; i < 5; i++) begin
      op = 4'h3; in_a = 8'hAA; in_valid = 1'b1;
      @(negedge clk);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_rslt", rslt, 8'h00);
      chk("bp_flags", {flag_c, flag_z, flag_p, flag_eq}, 4'b1100);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_release_out_valid", out_valid, 0);
    chk("bp_release_in_ready", in_ready, 1);

    run(4'h3, 8'h5C, 8'h00, 8'h5C, 8'h00, 4'b1000, 1);

    // Reset in the fourth EXEC cycle of a long op.
`ifdef ITER_ALU_MUL_EN
    accept_op(4'hA, 8'h0F, 8'h03, acc_rst);
`else
    accept_op(4'h8, 8'h01, 8'h08, acc_rst);
`endif
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midop_rst_out_valid", out_valid, 0);
    chk("midop_rst_in_ready", in_ready, 0);
    chk("midop_rst_rslt", rslt, 0);
    chk("midop_rst_rslt_hi", rslt_hi, 0);
    chk("midop_rst_flags", {flag_c, flag_z, flag_p, flag_eq}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1 chk("midop_release_in_ready", in_ready, 1);

    run(4'h0, 8'h12, 8'h34, 8'h46, 8'h00, 4'b0010, 1);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
